// File: rtl/cpu_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_timing_pkg
// Purpose  : Shared timing constants and sequence encodings for the 8227 core.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_timing_pkg;

    localparam int NUM_T        = 7;
    localparam int RESET_CYCLES = 7;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
    localparam int T6 = 6;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        IRQ   = 2'b01,
        NMI   = 2'b10,
        RESET = 2'b11
    } service_t;

    typedef enum logic {
        MODE_RESET_SEQ = 1'b0,
        MODE_RUN       = 1'b1
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/nmi_edge_latch.sv
`default_nettype none
// ============================================================================
// Module   : nmi_edge_latch
// Purpose  : Falling-edge NMI detector with a pending latch; a new edge beats a clear.
// Revision : 1.0 - initial release
// ============================================================================
module nmi_edge_latch (
    input  logic clk,
    input  logic nrst,
    input  logic i_nmi_n,
    input  logic i_clear,
    output logic o_pending
);

    logic r_nmi_prev;
    logic r_nmi_latch;
    logic w_fall;

    assign w_fall    = r_nmi_prev & ~i_nmi_n;
    assign o_pending = r_nmi_latch;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_nmi_prev  <= 1'b1;
            r_nmi_latch <= 1'b0;
        end else begin
            r_nmi_prev <= i_nmi_n;
            // A fresh edge on the clearing clk must not be lost.
            if (w_fall) begin
                r_nmi_latch <= 1'b1;
            end else if (i_clear) begin
                r_nmi_latch <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_cycle_sequencer
// Purpose  : One-hot T-state generator with RDY stall, reset sequence and
//            NMI/IRQ service selection at instruction boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_cycle_sequencer #(
    parameter int NUM_T        = cpu_timing_pkg::NUM_T,
    parameter int RESET_CYCLES = cpu_timing_pkg::RESET_CYCLES
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_slow_pulse,
    input  logic             i_rdy,
    input  logic             i_rw,
    input  logic             i_last_cycle,
    input  logic             i_nmi_n,
    input  logic             i_irq_n,
    input  logic             i_irq_mask,
    output logic             o_step,
    output logic             o_stalled,
    output logic [NUM_T-1:0] o_t_state,
    output logic             o_sync,
    output logic             o_reset_seq,
    output logic [1:0]       o_service_req,
    output logic             o_seq_error
);

    import cpu_timing_pkg::*;

    localparam int             CW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(RESET_CYCLES - 1);

    mode_t            r_mode;
    service_t         r_svc;
    logic [NUM_T-1:0] r_t_state;
    logic [CW-1:0]    r_rst_cnt;
    logic             r_seq_error;

    logic     w_stall_cond;
    logic     w_step;
    logic     w_boundary;
    logic     w_nmi_pending;
    logic     w_irq_take;
    service_t w_next_svc;

    assign w_stall_cond = ~i_rdy & i_rw;
    assign w_step       = i_slow_pulse & ~w_stall_cond;
    assign w_boundary   = w_step & (r_mode == MODE_RUN) & i_last_cycle;
    assign w_irq_take   = ~i_irq_n & ~i_irq_mask;

    always_comb begin
        w_next_svc = NONE;
        if (w_nmi_pending) begin
            w_next_svc = NMI;
        end else if (w_irq_take) begin
            w_next_svc = IRQ;
        end
    end

    nmi_edge_latch u_nmi_edge_latch (
        .clk       (clk),
        .nrst      (nrst),
        .i_nmi_n   (i_nmi_n),
        .i_clear   (w_boundary & w_nmi_pending),
        .o_pending (w_nmi_pending)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mode      <= MODE_RESET_SEQ;
            r_svc       <= RESET;
            r_t_state   <= NUM_T'(1) << T0;
            r_rst_cnt   <= '0;
            r_seq_error <= 1'b0;
        end else if (w_step) begin
            case (r_mode)
                MODE_RESET_SEQ: begin
                    if (r_rst_cnt == CNT_LAST) begin
                        r_mode    <= MODE_RUN;
                        r_svc     <= NONE;
                        r_t_state <= NUM_T'(1) << T0;
                        r_rst_cnt <= '0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                        r_t_state <= r_t_state << 1;
                    end
                end
                default: begin
                    if (i_last_cycle) begin
                        r_t_state <= NUM_T'(1) << T0;
                        r_svc     <= w_next_svc;
                    end else if (r_t_state[NUM_T-1]) begin
                        // Instruction overran the last T-state: park there and flag it.
                        r_seq_error <= 1'b1;
                    end else begin
                        r_t_state <= r_t_state << 1;
                    end
                end
            endcase
        end
    end

    assign o_step        = w_step;
    assign o_stalled     = i_slow_pulse & w_stall_cond;
    assign o_t_state     = r_t_state;
    assign o_reset_seq   = (r_mode == MODE_RESET_SEQ);
    assign o_service_req = r_svc;
    assign o_seq_error   = r_seq_error;
    assign o_sync        = (r_mode == MODE_RUN) & r_t_state[T0] & (r_svc == NONE);

endmodule
`default_nettype wire

// File: tb/tb_cpu_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_cycle_sequencer
// Purpose  : Scoreboard bench for cpu_cycle_sequencer scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_cycle_sequencer;

    logic       clk = 1'b0;
    logic       nrst;
    logic       slow_pulse;
    logic       rdy;
    logic       rw;
    logic       last_cycle;
    logic       nmi_n;
    logic       irq_n;
    logic       irq_mask;
    logic       step;
    logic       stalled;
    logic [6:0] t_state;
    logic       sync;
    logic       reset_seq;
    logic [1:0] service_req;
    logic       seq_error;

    typedef struct packed {
        logic [6:0] t;
        logic [1:0] svc;
        logic       rs;
        logic       sy;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    cpu_cycle_sequencer #(.NUM_T(7), .RESET_CYCLES(7)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .i_slow_pulse  (slow_pulse),
        .i_rdy         (rdy),
        .i_rw          (rw),
        .i_last_cycle  (last_cycle),
        .i_nmi_n       (nmi_n),
        .i_irq_n       (irq_n),
        .i_irq_mask    (irq_mask),
        .o_step        (step),
        .o_stalled     (stalled),
        .o_t_state     (t_state),
        .o_sync        (sync),
        .o_reset_seq   (reset_seq),
        .o_service_req (service_req),
        .o_seq_error   (seq_error)
    );

    function automatic exp_t mk(input int ti, input logic [1:0] svc,
                                input logic rs, input logic sy, input logic err);
        exp_t e;
        e.t   = 7'b1 << ti;
        e.svc = svc;
        e.rs  = rs;
        e.sy  = sy;
        e.err = err;
        return e;
    endfunction

    // One CPU cycle: pulse for one clk, then two idle clks. Starts and ends on a negedge.
    task automatic run_step(input logic lc, input logic exp_stall, input exp_t e, input string name);
        exp_t got;
        exp_t want;
        last_cycle = lc;
        slow_pulse = 1'b1;
        q.push_back(e);
        #1;
        n_vec++;
        if (stalled !== exp_stall || step !== ~exp_stall) begin
            n_miss++;
            $display("FAIL %s strobe: step=%b stalled=%b, required step=%b stalled=%b",
                     name, step, stalled, ~exp_stall, exp_stall);
        end
        @(negedge clk);
        slow_pulse = 1'b0;
        got  = {t_state, service_req, reset_seq, sync, seq_error};
        want = q.pop_front();
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s state: got t=%b svc=%b rs=%b sync=%b err=%b, required t=%b svc=%b rs=%b sync=%b err=%b",
                     name, got.t, got.svc, got.rs, got.sy, got.err,
                     want.t, want.svc, want.rs, want.sy, want.err);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string name);
        exp_t got;
        exp_t want;
        got  = {t_state, service_req, reset_seq, sync, seq_error};
        want = mk(0, 2'b11, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic reset_sequence(input string name);
        for (int i = 0; i < 7; i++) begin
            if (i < 6) run_step(1'(i & 1), 1'b0, mk(i + 1, 2'b11, 1'b1, 1'b0, 1'b0), name);
            else       run_step(1'b0, 1'b0, mk(0, 2'b00, 1'b0, 1'b1, 1'b0), name);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset_values");
        nrst = 1'b1;
        @(negedge clk);
        reset_sequence("reset_seq");
    endtask

    task automatic test_instr();
        run_step(1'b0, 1'b0, mk(1, 2'b00, 1'b0, 1'b0, 1'b0), "instr3_t1");
        run_step(1'b0, 1'b0, mk(2, 2'b00, 1'b0, 1'b0, 1'b0), "instr3_t2");
        run_step(1'b1, 1'b0, mk(0, 2'b00, 1'b0, 1'b1, 1'b0), "instr3_t0");
        run_step(1'b0, 1'b0, mk(1, 2'b00, 1'b0, 1'b0, 1'b0), "instr2_t1");
        run_step(1'b1, 1'b0, mk(0, 2'b00, 1'b0, 1'b1, 1'b0), "instr2_t0");
    endtask

    task automatic test_stall();
        run_step(1'b0, 1'b0, mk(1, 2'b00, 1'b0, 1'b0, 1'b0), "stall_pre");
        rdy = 1'b0;
        rw  = 1'b1;
        run_step(1'b0, 1'b1, mk(1, 2'b00, 1'b0, 1'b0, 1'b0), "stall_1");
        run_step(1'b1, 1'b1, mk(1, 2'b00, 1'b0, 1'b0, 1'b0), "stall_2");
        rw = 1'b0;
        run_step(1'b0, 1'b0, mk(2, 2'b00, 1'b0, 1'b0, 1'b0), "write_no_stall");
        rdy = 1'b1;
        rw  = 1'b1;
        run_step(1'b1, 1'b0, mk(0, 2'b00, 1'b0, 1'b1, 1'b0), "stall_end");
    endtask

    task automatic test_nmi();
        irq_n    = 1'b0;
        irq_mask = 1'b0;
        nmi_n    = 1'b0;
        run_step(1'b0, 1'b0, mk(1, 2'b00, 1'b0, 1'b0, 1'b0), "nmi_mid");
        run_step(1'b1, 1'b0, mk(0, 2'b10, 1'b0, 1'b0, 1'b0), "nmi_boundary");
        nmi_n = 1'b1;
        run_step(1'b0, 1'b0, mk(1, 2'b10, 1'b0, 1'b0, 1'b0), "nmi_body");
        run_step(1'b1, 1'b0, mk(0, 2'b01, 1'b0, 1'b0, 1'b0), "irq_after_nmi");
        irq_n = 1'b1;
        run_step(1'b1, 1'b0, mk(0, 2'b00, 1'b0, 1'b1, 1'b0), "back_to_fetch");
    endtask

    task automatic test_irq_mask_edge();
        irq_n    = 1'b0;
        irq_mask = 1'b1;
        run_step(1'b1, 1'b0, mk(0, 2'b00, 1'b0, 1'b1, 1'b0), "irq_masked");
        nmi_n = 1'b0;
        run_step(1'b1, 1'b0, mk(0, 2'b00, 1'b0, 1'b1, 1'b0), "nmi_on_boundary");
        run_step(1'b1, 1'b0, mk(0, 2'b10, 1'b0, 1'b0, 1'b0), "nmi_deferred");
        run_step(1'b1, 1'b0, mk(0, 2'b00, 1'b0, 1'b1, 1'b0), "nmi_cleared");
        nmi_n = 1'b1;
        run_step(1'b0, 1'b0, mk(1, 2'b00, 1'b0, 1'b0, 1'b0), "pre_edge");
        nmi_n = 1'b0;
        @(negedge clk);
        nmi_n = 1'b1;
        @(negedge clk);
        nmi_n = 1'b0;
        run_step(1'b1, 1'b0, mk(0, 2'b10, 1'b0, 1'b0, 1'b0), "edge_wins_a");
        run_step(1'b1, 1'b0, mk(0, 2'b10, 1'b0, 1'b0, 1'b0), "edge_wins_b");
        nmi_n = 1'b1;
        run_step(1'b1, 1'b0, mk(0, 2'b00, 1'b0, 1'b1, 1'b0), "edge_wins_done");
        irq_n    = 1'b1;
        irq_mask = 1'b0;
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 6; i++)
            run_step(1'b0, 1'b0, mk(i, 2'b00, 1'b0, 1'b0, 1'b0), "overrun_walk");
        run_step(1'b0, 1'b0, mk(6, 2'b00, 1'b0, 1'b0, 1'b1), "overrun_hold");
        run_step(1'b0, 1'b0, mk(6, 2'b00, 1'b0, 1'b0, 1'b1), "overrun_sticky");
        run_step(1'b1, 1'b0, mk(0, 2'b00, 1'b0, 1'b1, 1'b1), "overrun_recover");
        for (int i = 1; i <= 4; i++)
            run_step(1'b0, 1'b0, mk(i, 2'b00, 1'b0, 1'b0, 1'b1), "to_t4");
        #2;
        nrst = 1'b0;
        #1;
        check_reset_values("async_reset_t4");
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        reset_sequence("reset_rerun");
    endtask

    initial begin
        nrst       = 1'b0;
        slow_pulse = 1'b0;
        rdy        = 1'b1;
        rw         = 1'b1;
        last_cycle = 1'b0;
        nmi_n      = 1'b1;
        irq_n      = 1'b1;
        irq_mask   = 1'b0;
        test_reset();
        test_instr();
        test_stall();
        test_nmi();
        test_irq_mask_edge();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
